// File: rtl/alu_sin_deserializer.sv
// alu_sin_deserializer: receives 11-bit serial packets, gathers operand bytes plus a
// command packet and emits one CRC/opcode-checked operation for the ALU core.
module alu_sin_deserializer #(
  parameter int N_DATA = 8,
  parameter int CRC_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        frame_err,
  output logic        busy
);
  localparam int CW = $clog2(N_DATA + 1);
  localparam int FW = 8 * N_DATA;
  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;
  state_t state;
  logic [3:0] bit_cnt;
  logic [CW-1:0] data_cnt;
  logic [8:0] sh;
  logic [7:0] data_q [N_DATA];
  logic [FW-1:0] frame;
  logic [2:0] op;
  logic e_d, e_c, e_o, ok;
  function automatic logic [CRC_W-1:0] crc4(input logic [FW+3:0] v);
    logic [CRC_W-1:0] c;
    c = '0;
    for (int i = FW + 3; i >= 0; i--)
      c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ v[i]) ? CRC_W'(3) : '0);
    return c;
  endfunction
  // sh holds {type, payload} once the stop bit is on sin
  always_comb begin
    frame = '0;
    for (int i = 0; i < N_DATA; i++) frame[FW-1-8*i -: 8] = data_q[i];
    op = sh[6:4];
    e_d = data_cnt != CW'(N_DATA);
    e_c = !e_d && sh[CRC_W-1:0] != crc4({frame, 1'b1, op});
    e_o = !e_d && !e_c && !(op inside {3'b000, 3'b001, 3'b100, 3'b101});
    ok = sh[8] && !e_d && !e_c && !e_o;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      data_cnt <= '0;
      sh <= '0;
      for (int i = 0; i < N_DATA; i++) data_q[i] <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
      out_op <= '0;
      err_data <= 1'b0;
      err_crc <= 1'b0;
      err_op <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!sin) begin
          state <= RX;
          bit_cnt <= 4'd1;
          busy <= 1'b1;
        end
        RX: if (bit_cnt != 4'd10) begin
          sh <= {sh[7:0], sin};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          state <= CHECK;
          bit_cnt <= '0;
          busy <= 1'b0;
          if (!sin) begin
            frame_err <= 1'b1;
            data_cnt <= '0;
          end else if (!sh[8] && data_cnt != CW'(N_DATA)) begin
            for (int i = 0; i < N_DATA; i++) if (data_cnt == CW'(i)) data_q[i] <= sh[7:0];
            data_cnt <= data_cnt + CW'(1);
          end else begin
            // a command, or a data packet overflowing a full buffer
            out_valid <= 1'b1;
            data_cnt <= '0;
            err_data <= !sh[8] || e_d;
            err_crc <= sh[8] && e_c;
            err_op <= sh[8] && e_o;
            out_b <= ok ? frame[FW-1 -: 32] : '0;
            out_a <= ok ? frame[FW-33 -: 32] : '0;
            out_op <= ok ? op : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sin_deserializer.sv
// tb_alu_sin_deserializer: drives serial packets and checks decoded frames against
// a queue-based frame model with a polynomial-division CRC.
module tb_alu_sin_deserializer;
  logic clk = 0, rst = 1, sin = 1;
  logic out_valid, err_data, err_crc, err_op, frame_err, busy;
  logic [31:0] out_a, out_b;
  logic [2:0] out_op;
  int checks = 0, errors = 0, nvalid = 0;
  logic [7:0] mq[$];
  logic [31:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  logic m_ed = 0, m_ec = 0, m_eo = 0;

  alu_sin_deserializer dut (
    .clk(clk), .rst(rst), .sin(sin), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .err_data(err_data), .err_crc(err_crc), .err_op(err_op),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) nvalid++;

  // remainder of msg * x^4 divided by x^4+x+1, by long division
  function automatic logic [3:0] ref_crc(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic legal(input logic [2:0] op);
    return op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5;
  endfunction

  task automatic model_reset();
    mq.delete();
    {m_a, m_b, m_op, m_ed, m_ec, m_eo} = '0;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop);
    logic ev, ef;
    logic [63:0] f;
    logic [10:0] bits;
    ev = 0;
    ef = 0;
    if (!stop) begin
      ef = 1;
      mq.delete();
    end else if (!typ) begin
      if (mq.size() == 8) begin
        ev = 1;
        {m_a, m_b, m_op, m_ec, m_eo} = '0;
        m_ed = 1;
        mq.delete();
      end else mq.push_back(pl);
    end else begin
      ev = 1;
      f = '0;
      foreach (mq[i]) f = {f[55:0], mq[i]};
      m_ed = mq.size() != 8;
      m_ec = !m_ed && pl[3:0] != ref_crc({f, 1'b1, pl[6:4]});
      m_eo = !m_ed && !m_ec && !legal(pl[6:4]);
      if (m_ed || m_ec || m_eo) {m_a, m_b, m_op} = '0;
      else begin
        m_b = f[63:32];
        m_a = f[31:0];
        m_op = pl[6:4];
      end
      mq.delete();
    end
    bits = {1'b0, typ, pl, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      @(posedge clk);
      #1;
      if (i == 10) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rx: got %b want 1", busy); end
      end
    end
    checks++;
    if (out_valid !== ev) begin errors++; $display("FAIL out_valid: got %b want %b", out_valid, ev); end
    checks++;
    if (frame_err !== ef) begin errors++; $display("FAIL frame_err: got %b want %b", frame_err, ef); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_check: got %b want 0", busy); end
    checks++;
    if ({out_a, out_b, out_op} !== {m_a, m_b, m_op}) begin
      errors++;
      $display("FAIL operands: got a=%h b=%h op=%0d want a=%h b=%h op=%0d", out_a, out_b, out_op, m_a, m_b, m_op);
    end
    checks++;
    if ({err_data, err_crc, err_op} !== {m_ed, m_ec, m_eo}) begin
      errors++;
      $display("FAIL err_flags: got %b%b%b want %b%b%b", err_data, err_crc, err_op, m_ed, m_ec, m_eo);
    end
    sin = 1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: got valid=%b ferr=%b want 0 0", out_valid, frame_err);
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc_flip, input logic pl7);
    logic [63:0] f;
    f = {b, a};
    for (int i = 0; i < 8; i++) send_pkt(1'b0, f[63-8*i -: 8], 1'b1);
    send_pkt(1'b1, {pl7, op, ref_crc({b, a, 1'b1, op}) ^ crc_flip}, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1;
    sin = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_op, err_data, err_crc, err_op, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%0d busy=%b want all 0", out_valid, out_a, out_b, out_op, busy);
    end
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_zero_frame();
    for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'h00, 1'b1);
    send_pkt(1'b1, 8'b0000_1011, 1'b1);
    checks++;
    if ({out_a, out_b, out_op, err_data, err_crc, err_op} !== '0) begin
      errors++;
      $display("FAIL zero_frame: got a=%h b=%h op=%0d flags=%b%b%b want zeros", out_a, out_b, out_op, err_data, err_crc, err_op);
    end
  endtask

  task automatic test_valid_and_crc();
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 4'h0, 1'b0);
    checks++;
    if (out_b !== 32'h1 || out_a !== 32'hFFFF_FFFF || out_op !== 3'b100) begin
      errors++;
      $display("FAIL add_frame: got a=%h b=%h op=%0d want a=ffffffff b=00000001 op=4", out_a, out_b, out_op);
    end
    send_frame(32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 4'hF, 1'b0);
    checks++;
    if (err_crc !== 1'b1) begin errors++; $display("FAIL crc_err: got %b want 1", err_crc); end
  endtask

  task automatic test_data_count();
    for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'(i + 1), 1'b1);
    send_pkt(1'b1, {1'b0, 3'b000, 4'h0}, 1'b1);
    checks++;
    if (err_data !== 1'b1) begin errors++; $display("FAIL short_frame: got err_data=%b want 1", err_data); end
    for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'hFF, 1'b1);
    checks++;
    if (err_data !== 1'b1 || nvalid == 0) begin errors++; $display("FAIL overflow: got err_data=%b want 1", err_data); end
    send_frame(32'hDEAD_BEEF, 32'h0123_4567, 3'b101, 4'h0, 1'b1);
  endtask

  task automatic test_op_and_stop();
    int n0;
    send_frame(32'h1111_2222, 32'h3333_4444, 3'b010, 4'h0, 1'b0);
    checks++;
    if (err_op !== 1'b1) begin errors++; $display("FAIL bad_op: got err_op=%b want 1", err_op); end
    for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'(8'h10 * i), 1'b1);
    n0 = nvalid;
    send_pkt(1'b1, 8'h0A, 1'b0);
    checks++;
    if (nvalid !== n0) begin errors++; $display("FAIL stop_err_valid: got %0d pulses want 0", nvalid - n0); end
    send_frame(32'hCAFE_F00D, 32'h8000_0000, 3'b001, 4'h0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int n0;
    logic [10:0] bits;
    for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'hA5, 1'b1);
    bits = {1'b0, 1'b0, 8'h5A, 1'b1};
    for (int i = 10; i >= 6; i--) begin
      sin = bits[i];
      @(posedge clk);
      #1;
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({out_valid, out_a, out_b, out_op, err_data, err_crc, err_op, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got v=%b a=%h b=%h busy=%b want all 0", out_valid, out_a, out_b, busy);
    end
    sin = 1;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    n0 = nvalid;
    send_frame(32'h0BAD_F00D, 32'h7777_0001, 3'b000, 4'h0, 1'b0);
    checks++;
    if (nvalid !== n0 + 1) begin errors++; $display("FAIL post_reset_count: got %0d pulses want 1", nvalid - n0); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      logic [31:0] a, b;
      logic [2:0] op;
      int kind;
      a = $urandom;
      b = $urandom;
      op = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 4);
      if (kind == 1) send_frame(b, a, op, 4'($urandom_range(1, 15)), 1'($urandom));
      else if (kind == 2) begin
        for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
        send_pkt(1'b1, 8'($urandom), 1'b1);
      end else if (kind == 3) begin
        for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'($urandom), i != 3);
        send_pkt(1'b1, {1'b0, op, ref_crc({b, a, 1'b1, op})}, 1'b1);
      end else send_frame(b, a, op, 4'h0, 1'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_frame();
    test_valid_and_crc();
    test_data_count();
    test_op_and_stop();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
